bus_arbiter: RTL and testbench

- Two-master arbiter for the serial bus. Decides which of m1/m2 owns the shared address/data path.
- Drives the master-select inputs (m1, m2) of the address decoder.
- Tracks split transactions, so a master parked by a split slave is skipped until the slave releases it. It then gets priority on resume.
- Bounds every tenure with a timeout.

---
 rtl/bus_arbiter_if.sv | 16 +
 rtl/bus_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request/grant and split/done handshake bundle between the masters, the
// address decoder and the two-master bus arbiter.
interface bus_arbiter_if;
  logic m1_req, m2_req, xfer_done, split_in, split_release;
  logic m1_grant, m2_grant, bus_busy, m1_split, m2_split, timeout, err;

  modport master (
    output m1_req, m2_req, xfer_done, split_in, split_release,
    input  m1_grant, m2_grant, bus_busy, m1_split, m2_split, timeout, err
  );

  modport slave (
    input  m1_req, m2_req, xfer_done, split_in, split_release,
    output m1_grant, m2_grant, bus_busy, m1_split, m2_split, timeout, err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master serial-bus arbiter: fixed or round-robin priority, split-transaction
// parking with resume priority, tenure timeout and a one-cycle turnaround gap.
module bus_arbiter #(
  parameter int RR_EN   = 0,
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input logic          clk,
  input logic          rstn,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_M1, OWN_M2, RELEASE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_m2;   // 1: m2 held the most recent grant
  logic [1:0]    rp;        // resume pending, one-hot: [0]=m1, [1]=m2

  logic elig1, elig2, pick1, pick2;
  logic own_req, to_hit, exit_now;
  logic s1_n, s2_n, err_n;
  logic [1:0] rp_n;

  assign elig1    = bus.m1_req & ~bus.m1_split;
  assign elig2    = bus.m2_req & ~bus.m2_split;
  assign own_req  = (state == OWN_M1) ? bus.m1_req : bus.m2_req;
  assign to_hit   = (cnt == CW'(TIMEOUT - 1));
  assign exit_now = bus.split_in | bus.xfer_done | ~own_req | to_hit;

  // Resumed master first, then the lone eligible one, then the tie-break.
  always_comb begin
    pick1 = 1'b0;
    pick2 = 1'b0;
    if (rp[0] && elig1)       pick1 = 1'b1;
    else if (rp[1] && elig2)  pick2 = 1'b1;
    else if (elig1 && !elig2) pick1 = 1'b1;
    else if (elig2 && !elig1) pick2 = 1'b1;
    else if (elig1 && elig2) begin
      if (RR_EN != 0 && !last_m2) pick2 = 1'b1;
      else                        pick1 = 1'b1;
    end
  end

  // Split bookkeeping: split_in lands first, split_release is applied on top,
  // so a coincident pair leaves the flag clear but the resume pending.
  always_comb begin
    s1_n  = bus.m1_split;
    s2_n  = bus.m2_split;
    rp_n  = rp;
    err_n = 1'b0;
    if (state == IDLE) begin
      rp_n[0] = rp[0] & ~pick1;
      rp_n[1] = rp[1] & ~pick2;
    end
    if (bus.split_in && state == OWN_M1) begin
      if (!bus.m2_split) s1_n  = 1'b1;
      else               err_n = 1'b1;
    end
    if (bus.split_in && state == OWN_M2) begin
      if (!bus.m1_split) s2_n  = 1'b1;
      else               err_n = 1'b1;
    end
    if (bus.split_release) begin
      if (s1_n) begin
        s1_n = 1'b0;
        rp_n = 2'b01;
      end else if (s2_n) begin
        s2_n = 1'b0;
        rp_n = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      last_m2      <= 1'b1;
      rp           <= 2'b00;
      bus.m1_grant <= 1'b0;
      bus.m2_grant <= 1'b0;
      bus.bus_busy <= 1'b0;
      bus.m1_split <= 1'b0;
      bus.m2_split <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.m1_split <= s1_n;
      bus.m2_split <= s2_n;
      rp           <= rp_n;
      bus.err      <= err_n;
      bus.timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick1 || pick2) begin
            state        <= pick1 ? OWN_M1 : OWN_M2;
            bus.m1_grant <= pick1;
            bus.m2_grant <= pick2;
            bus.bus_busy <= 1'b1;
            cnt          <= '0;
            last_m2      <= pick2;
          end
        end
        OWN_M1, OWN_M2: begin
          if (exit_now) begin
            state        <= RELEASE;
            bus.m1_grant <= 1'b0;
            bus.m2_grant <= 1'b0;
            bus.timeout  <= ~bus.split_in & ~bus.xfer_done & own_req & to_hit;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          state        <= IDLE;
          bus.bus_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a fixed-priority and a round-robin instance share one
// stimulus stream and are compared against a tenure-level reference model.
module tb_bus_arbiter;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m1_req = 1'b0, m2_req = 1'b0, xfer_done = 1'b0, split_in = 1'b0, split_release = 1'b0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  bus_arbiter_if a0();
  bus_arbiter_if a1();
  assign a0.m1_req = m1_req;        assign a1.m1_req = m1_req;
  assign a0.m2_req = m2_req;        assign a1.m2_req = m2_req;
  assign a0.xfer_done = xfer_done;  assign a1.xfer_done = xfer_done;
  assign a0.split_in = split_in;    assign a1.split_in = split_in;
  assign a0.split_release = split_release;
  assign a1.split_release = split_release;

  bus_arbiter #(.RR_EN(0), .TIMEOUT(TO), .CW(8)) dut0 (.clk(clk), .rstn(rstn), .bus(a0));
  bus_arbiter #(.RR_EN(1), .TIMEOUT(TO), .CW(8)) dut1 (.clk(clk), .rstn(rstn), .bus(a1));

  // {m1_grant, m2_grant, bus_busy, m1_split, m2_split, timeout, err}
  logic [6:0] o0, o1;
  assign o0 = {a0.m1_grant, a0.m2_grant, a0.bus_busy, a0.m1_split, a0.m2_split, a0.timeout, a0.err};
  assign o1 = {a1.m1_grant, a1.m2_grant, a1.bus_busy, a1.m1_split, a1.m2_split, a1.timeout, a1.err};

  // Reference: who owns the bus (0 = nobody), whether we sit in the turnaround
  // gap, which masters are parked, who is owed the bus, and how long it's held.
  typedef struct packed {
    logic [1:0] owner;
    logic       gap;
    logic [2:1] park;
    logic [1:0] resume;
    logic [1:0] last;
    int         age;
    logic       to_p;
    logic       err_p;
  } mdl_t;

  localparam mdl_t MDL_RST = '{owner: 2'd0, gap: 1'b0, park: 2'b00, resume: 2'd0,
                               last: 2'd2, age: 0, to_p: 1'b0, err_p: 1'b0};

  function automatic mdl_t model_next(mdl_t s, bit rr, bit r1, bit r2, bit dn, bit si, bit sr);
    mdl_t n = s;
    logic [2:1] req, ok;
    logic [1:0] w;
    n.to_p = 1'b0;
    n.err_p = 1'b0;
    req = {r2, r1};
    ok = req & ~s.park;
    if (s.gap) begin
      n.gap = 1'b0;
    end else if (s.owner == 2'd0) begin
      w = 2'd0;
      if (s.resume == 2'd1 && ok[1])      w = 2'd1;
      else if (s.resume == 2'd2 && ok[2]) w = 2'd2;
      else if (ok == 2'b11)               w = rr ? (2'd3 - s.last) : 2'd1;
      else if (ok[1])                     w = 2'd1;
      else if (ok[2])                     w = 2'd2;
      if (w != 2'd0) begin
        n.owner = w;
        n.age = 0;
        n.last = w;
        if (s.resume == w) n.resume = 2'd0;
      end
    end else begin
      if (si) begin
        if (s.park[3 - int'(s.owner)]) n.err_p = 1'b1;
        else                            n.park[s.owner] = 1'b1;
        n.owner = 2'd0;
        n.gap = 1'b1;
      end else if (dn || !req[s.owner]) begin
        n.owner = 2'd0;
        n.gap = 1'b1;
      end else if (s.age == TO - 1) begin
        n.owner = 2'd0;
        n.gap = 1'b1;
        n.to_p = 1'b1;
      end else begin
        n.age = (s.age >= 255) ? 255 : s.age + 1;
      end
    end
    if (sr) begin
      if (n.park[1]) begin
        n.park[1] = 1'b0;
        n.resume = 2'd1;
      end else if (n.park[2]) begin
        n.park[2] = 1'b0;
        n.resume = 2'd2;
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] exp_vec(mdl_t m);
    return {m.owner == 2'd1, m.owner == 2'd2, (m.owner != 2'd0) || m.gap,
            m.park[1], m.park[2], m.to_p, m.err_p};
  endfunction

  mdl_t md0, md1;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      md0 <= MDL_RST;
      md1 <= MDL_RST;
    end else begin
      md0 <= model_next(md0, 1'b0, m1_req, m2_req, xfer_done, split_in, split_release);
      md1 <= model_next(md1, 1'b1, m1_req, m2_req, xfer_done, split_in, split_release);
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o0, o1} !== 14'b0) begin
      errors++; $display("FAIL reset_outputs: got %b/%b need all zero", o0, o1);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o0, o1} !== {exp_vec(md0), exp_vec(md1)} || o0 !== 7'b0) begin
      errors++; $display("FAIL reset_idle: got %b/%b need %b/%b", o0, o1, exp_vec(md0), exp_vec(md1));
    end
  endtask

  task automatic test_fixed_priority();
    m1_req = 1'b1; m2_req = 1'b1;
    @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b10 || o1[6:5] !== 2'b10) begin
      errors++; $display("FAIL fixed_first_grant: got %b/%b need 10/10", o0[6:5], o1[6:5]);
    end
    repeat (3) @(negedge clk);
    xfer_done = 1'b1; m1_req = 1'b0;
    @(negedge clk);
    xfer_done = 1'b0;
    checks++;
    if (o0[6:4] !== 3'b001 || o1[6:4] !== 3'b001) begin
      errors++; $display("FAIL fixed_release_gap: got %b/%b need 001/001", o0[6:4], o1[6:4]);
    end
    @(negedge clk);
    checks++;
    if (o0[6:4] !== 3'b000) begin
      errors++; $display("FAIL fixed_idle: got %b need 000", o0[6:4]);
    end
    @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b01 || {o0, o1} !== {exp_vec(md0), exp_vec(md1)}) begin
      errors++; $display("FAIL fixed_m2_after_gap: got %b/%b need %b/%b", o0, o1, exp_vec(md0), exp_vec(md1));
    end
    xfer_done = 1'b1; m2_req = 1'b0;
    @(negedge clk);
    xfer_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    m1_req = 1'b1; m2_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o1[6:5] !== ((k % 2 == 0) ? 2'b10 : 2'b01) || o0[6:5] !== 2'b10 ||
          {o0, o1} !== {exp_vec(md0), exp_vec(md1)}) begin
        errors++; $display("FAIL rr_tenure_%0d: got %b/%b need %b/%b", k, o0, o1, exp_vec(md0), exp_vec(md1));
      end
      repeat (3) @(negedge clk);
      xfer_done = 1'b1;
      @(negedge clk);
      xfer_done = 1'b0;
      checks++;
      if (o1[6:4] !== 3'b001) begin
        errors++; $display("FAIL rr_gap_%0d: got %b need 001", k, o1[6:4]);
      end
      repeat (2) @(negedge clk);
    end
    m1_req = 1'b0; m2_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_split();
    m1_req = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);
    split_in = 1'b1;
    @(negedge clk);
    split_in = 1'b0; m2_req = 1'b1;
    checks++;
    if (o0[6:3] !== 4'b0011 || o1[6:3] !== 4'b0011) begin
      errors++; $display("FAIL split_park_m1: got %b/%b need 0011/0011", o0[6:3], o1[6:3]);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b01 || o1[6:5] !== 2'b01) begin
      errors++; $display("FAIL split_m2_granted: got %b/%b need 01/01", o0[6:5], o1[6:5]);
    end
    repeat (2) @(negedge clk);
    split_release = 1'b1;
    @(negedge clk);
    split_release = 1'b0;
    checks++;
    if (o0[5:3] !== 3'b110 || o1[5:3] !== 3'b110) begin
      errors++; $display("FAIL split_release_m1: got %b/%b need 110/110", o0[5:3], o1[5:3]);
    end
    xfer_done = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b10 || o1[6:5] !== 2'b10) begin
      errors++; $display("FAIL split_resume_m1: got %b/%b need 10/10", o0[6:5], o1[6:5]);
    end
    // Mirror case: m2 parked and resumed must beat fixed priority of m1.
    m1_req = 1'b0;
    repeat (3) @(negedge clk);
    split_in = 1'b1;
    @(negedge clk);
    split_in = 1'b0; m1_req = 1'b1;
    repeat (2) @(negedge clk);
    split_release = 1'b1;
    @(negedge clk);
    split_release = 1'b0; xfer_done = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b01 || {o0, o1} !== {exp_vec(md0), exp_vec(md1)}) begin
      errors++; $display("FAIL split_resume_m2: got %b/%b need %b/%b", o0, o1, exp_vec(md0), exp_vec(md1));
    end
    m1_req = 1'b0; m2_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int k;
    m2_req = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      for (k = 0; k < 200 && o0[5] === 1'b1; k++) @(negedge clk);
      checks++;
      if (k != TO || o0[1] !== 1'b1 || o1[1] !== 1'b1 || o0[5] !== 1'b0) begin
        errors++; $display("FAIL timeout_%0d: held %0d cycles to=%b/%b need %0d cycles to=1", t, k, o0[1], o1[1], TO);
      end
      @(negedge clk);
      checks++;
      if (o0[1] !== 1'b0) begin
        errors++; $display("FAIL timeout_pulse_%0d: got %b need 0", t, o0[1]);
      end
      @(negedge clk);
    end
    m2_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_second_split();
    m1_req = 1'b1;
    @(negedge clk);
    split_in = 1'b1;
    @(negedge clk);
    split_in = 1'b0; m2_req = 1'b1;
    repeat (2) @(negedge clk);
    split_in = 1'b1;
    @(negedge clk);
    split_in = 1'b0;
    checks++;
    if (o0[6:0] !== 7'b0011001 || o1[6:0] !== 7'b0011001) begin
      errors++; $display("FAIL second_split_err: got %b/%b need 0011001", o0, o1);
    end
    @(negedge clk);
    checks++;
    if (o0[0] !== 1'b0 || {o0, o1} !== {exp_vec(md0), exp_vec(md1)}) begin
      errors++; $display("FAIL second_split_pulse: got %b/%b need %b/%b", o0, o1, exp_vec(md0), exp_vec(md1));
    end
    split_release = 1'b1;
    @(negedge clk);
    split_release = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({o0, o1} !== 14'b0) begin
      errors++; $display("FAIL reset_mid_async: got %b/%b need all zero", o0, o1);
    end
    @(negedge clk);
    rstn = 1'b1; m2_req = 1'b1;
    @(negedge clk);
    checks++;
    if (o0[6:5] !== 2'b10 || o1[6:5] !== 2'b10) begin
      errors++; $display("FAIL reset_mid_first_grant: got %b/%b need 10/10", o0[6:5], o1[6:5]);
    end
    m1_req = 1'b0; m2_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if ({o0, o1} !== {exp_vec(md0), exp_vec(md1)}) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_cyc_%0d: got %b/%b need %b/%b", c, o0, o1, exp_vec(md0), exp_vec(md1));
      end
      if ($urandom_range(7) == 0) m1_req = ~m1_req;
      if ($urandom_range(7) == 0) m2_req = ~m2_req;
      xfer_done     = ((c / 500) % 2 == 0) ? ($urandom_range(5) == 0) : ($urandom_range(149) == 0);
      split_in      = ($urandom_range(9) == 0);
      split_release = ($urandom_range(8) == 0);
    end
    m1_req = 1'b0; m2_req = 1'b0; xfer_done = 1'b0; split_in = 1'b0; split_release = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_split();
    test_timeout();
    test_second_split();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
